// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and
// block-oriented data memory. Stalls the CPU through busywait while a line is evicted or refilled.
module data_cache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [1:0]   fsm_state
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    // Handshake with memory: mem_read/mem_write is a request held steady until the
    // edge at which mem_busywait is sampled low; that edge completes the transfer.
    state_t                state;
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [127:0]          data [LINES];
    logic [127:0]          fill_block;
    logic [27:0]           miss_block;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit;
    logic                  request;
    logic                  unused_byte_offset;

    assign idx                = address[INDEX_BITS+3:4];
    assign tag                = address[31:INDEX_BITS+4];
    assign word               = address[3:2];
    assign miss_idx           = miss_block[INDEX_BITS-1:0];
    assign miss_tag           = miss_block[27:INDEX_BITS];
    assign unused_byte_offset = ^address[1:0];

    assign request   = read || write;
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign busywait  = request && (!hit || state != IDLE);
    assign readdata  = hit ? data[idx][{word, 5'b00000} +: 32] : 32'd0;
    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            miss_block    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write && hit) begin
                        data[idx][{word, 5'b00000} +: 32] <= writedata;
                        dirty[idx]                        <= 1'b1;
                    end else if (request && !hit) begin
                        // Latch the missing block so a wandering request cannot corrupt the refill.
                        miss_block <= address[31:4];
                        if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tags[idx], idx};
                            mem_writedata <= data[idx];
                        end else begin
                            state       <= ALLOCATE;
                            mem_read    <= 1'b1;
                            mem_address <= address[31:4];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        mem_write <= 1'b0;
                        if (request) begin
                            state       <= ALLOCATE;
                            mem_read    <= 1'b1;
                            mem_address <= miss_block;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (!mem_busywait) begin
                        mem_read   <= 1'b0;
                        fill_block <= mem_readdata;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    data[miss_idx]  <= fill_block;
                    tags[miss_idx]  <= miss_tag;
                    valid[miss_idx] <= 1'b1;
                    dirty[miss_idx] <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: a latency-programmable block memory, a flat word-level golden
// memory and a per-index hit/miss model predict stalls, evictions, refills and load data.
module tb_data_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         read, write;
    logic [31:0]  address, writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read, mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata, mem_readdata;
    logic         mem_busywait;
    logic [1:0]   fsm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_cache_ctrl dut (
        .CLK           (clk),
        .RESET         (rst),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .fsm_state     (fsm_state)
    );

    // Block memory: 64 blocks, busy for mem_lat cycles of each request, then one ready cycle.
    logic [127:0] dram [0:63];
    int           mem_lat = 3;
    int           mem_cnt = 0;

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt < mem_lat);
    assign mem_readdata = dram[mem_address[5:0]];

    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            if (mem_cnt < mem_lat) mem_cnt <= mem_cnt + 1;
            else begin
                mem_cnt <= 0;
                if (mem_write) dram[mem_address[5:0]] <= mem_writedata;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Reference: what the CPU should see as memory, plus which blocks each index holds.
    logic [31:0] golden [0:255];
    bit          m_valid [0:7];
    bit          m_dirty [0:7];
    int          m_tag   [0:7];

    int          rd_cnt = 0, wb_cnt = 0;
    logic [27:0] last_rd_addr, last_wb_addr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] golden_block(input logic [27:0] b);
        int base;
        base = int'(b[5:0]) * 4;
        return {golden[base+3], golden[base+2], golden[base+1], golden[base]};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_read || mem_write) check("mem_rd_wr_exclusive", 128'(mem_read && mem_write), 128'd0);
            if (mem_write && !mem_busywait) begin
                wb_cnt++;
                last_wb_addr = mem_address;
                check("wb_data", mem_writedata, golden_block(mem_address));
            end
            if (mem_read && !mem_busywait) begin
                rd_cnt++;
                last_rd_addr = mem_address;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        for (int w = 0; w < 256; w++) golden[w] = dram[w/4][(w%4)*32 +: 32];
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        int          idx, tg, exp_stall, stall, rd0, wb0;
        bit          hit, dirty_victim;
        logic [27:0] victim;
        idx          = int'(addr[6:4]);
        tg           = int'(addr[31:7]);
        hit          = m_valid[idx] && (m_tag[idx] == tg);
        dirty_victim = !hit && m_valid[idx] && m_dirty[idx];
        victim       = {m_tag[idx][24:0], addr[6:4]};
        exp_stall    = hit ? 0 : (dirty_victim ? 2 * (mem_lat + 1) + 2 : mem_lat + 3);
        rd0 = rd_cnt;
        wb0 = wb_cnt;

        @(negedge clk);
        read = rd; write = wr; address = addr; writedata = wdata;
        #1;
        stall = 0;
        while (busywait && stall < 200) begin
            stall++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 128'(stall), 128'(exp_stall));
        if (rd && !wr) check("readdata", 128'(readdata), 128'(golden[addr[9:2]]));
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        check("refill_count", 128'(rd_cnt - rd0), hit ? 128'd0 : 128'd1);
        if (!hit) check("refill_addr", 128'(last_rd_addr), 128'(addr[31:4]));
        check("evict_count", 128'(wb_cnt - wb0), 128'(dirty_victim));
        if (dirty_victim) check("evict_addr", 128'(last_wb_addr), 128'(victim));

        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (!hit) m_dirty[idx] = 1'b0;
        if (wr) begin
            m_dirty[idx]       = 1'b1;
            golden[addr[9:2]]  = wdata;
        end
    endtask

    initial begin
        int kind, seen;
        logic [31:0] a;
        for (int b = 0; b < 64; b++) dram[b] = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_address", 128'(mem_address), 128'd0);
        check("rst_mem_writedata", mem_writedata, 128'd0);
        check("rst_busywait", 128'(busywait), 128'd0);
        check("rst_readdata", 128'(readdata), 128'd0);
        check("rst_state", 128'(fsm_state), 128'd0);

        mem_lat = 3;
        do_op(1, 0, 32'h0000_0044, 0);             // cold miss, six stall cycles
        do_op(1, 0, 32'h0000_0044, 0);             // hit, no stall
        do_op(0, 1, 32'h0000_0044, 32'hDEAD_BEEF); // write hit
        do_op(1, 0, 32'h0000_00C4, 0);             // conflict: evict dirty block 4, refill 0xC
        do_op(0, 1, 32'h0000_0100, 32'h1234_5678); // write miss, clean victim
        do_op(1, 0, 32'h0000_0100, 0);
        do_op(1, 1, 32'h0000_0104, 32'hCAFE_F00D); // read+write on a hit acts as a write
        do_op(1, 0, 32'h0000_0180, 0);             // evicts dirty block 0x10

        // Reset in the middle of a refill.
        mem_lat = 5;
        @(negedge clk);
        read = 1'b1; address = 32'h0000_0244;
        seen = 0;
        while (!mem_read && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("alloc_reached", 128'(mem_read), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_mem_read", 128'(mem_read), 128'd0);
        check("rst_mid_state", 128'(fsm_state), 128'd0);
        check("rst_mid_busywait", 128'(busywait), 128'd1);
        check("rst_mid_readdata", 128'(readdata), 128'd0);
        @(negedge clk);
        rst = 1'b0; read = 1'b0;
        model_reset();
        do_op(1, 0, 32'h0000_0244, 0);             // misses again after reset
        do_op(1, 0, 32'h0000_0044, 0);

        for (int n = 0; n < 400; n++) begin
            mem_lat = $urandom_range(0, 4);
            a       = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00};
            kind    = $urandom_range(0, 4);
            if (kind <= 1)      do_op(1, 0, a, 0);
            else if (kind <= 3) do_op(0, 1, a, $urandom);
            else                do_op(1, 1, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
